conv2d_line_buffer: RTL and testbench

// - Row-buffering stage directly upstream of the conv2d window/MAC logic.
// - Accepts a raster pixel stream and emits one vertical column of kernel_rows_p pixels per input pixel.
// - Each output column holds the current pixel plus the same column from the previous kernel_rows_p-1 rows.
// - Previous rows are stored in kernel_rows_p-1 ram_1r1w_sync instances. Read is synchronous, so read data arrives 1 cycle after address.

---
 rtl/conv2d_line_buffer.sv | 210 +++++++++++++++++++++
 tb/tb_conv2d_line_buffer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_line_buffer.sv
// -----------------------------------------------------------------------------
// conv2d_line_buffer
//
// Purpose:
//   Row-buffering stage in front of the conv2d window/MAC logic. It accepts a
//   raster-order pixel stream. For every input pixel it emits one vertical
//   column of kernel_rows_p pixels: the current pixel plus the pixel at the
//   same column in each of the previous kernel_rows_p-1 rows. The previous
//   rows live in kernel_rows_p-1 synchronous-read RAMs. These RAMs form a
//   vertical shift chain: every accepted pixel shifts its column up by one row.
//
// Parameters:
//   width_p        bits per pixel
//   line_width_p   pixels per image row (>= 2)
//   kernel_rows_p  window height (>= 2)
//
// Ports:
//   clk_i      in   1                      single clock, rising edge
//   reset_i    in   1                      synchronous, active-high reset
//   valid_i    in   1                      input pixel valid
//   data_i     in   width_p                input pixel, raster order
//   ready_o    out  1                      block can accept data_i this cycle
//   valid_o    out  1                      data_o holds a complete column
//   data_o     out  kernel_rows_p*width_p  [width_p-1:0] = current row,
//                                          top slice = oldest row
//   ready_i    in   1                      downstream accepts data_o
//   eol_o      out  1                      (CONV2D_LINE_BUFFER_EOL_EN only)
//                                          emitted column is the last of a row
//
// Configuration macro:
//   CONV2D_LINE_BUFFER_EOL_EN  adds the eol_o output.
// -----------------------------------------------------------------------------

module ram_1r1w_sync #(
    parameter int width_p = 8,
    parameter int els_p   = 16
) (
    input  logic                     clk_i,
    input  logic                     wr_v_i,
    input  logic [$clog2(els_p)-1:0] wr_addr_i,
    input  logic [width_p-1:0]       wr_data_i,
    input  logic                     rd_valid_i,
    input  logic [$clog2(els_p)-1:0] rd_addr_i,
    output logic [width_p-1:0]       rd_data_o
);

    logic [width_p-1:0] mem_q [els_p];
    logic [width_p-1:0] rd_data_q;

    // NOTE: storage arrays get no reset so that they map onto RAM macros. The
    // read register keeps its value while rd_valid_i is low.
    always_ff @(posedge clk_i) begin
        if (wr_v_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        // Non-blocking read of mem_q gives read-before-write on a collision.
        if (rd_valid_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

module conv2d_line_buffer #(
    parameter int width_p       = 8,
    parameter int line_width_p  = 16,
    parameter int kernel_rows_p = 3
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             valid_i,
    input  logic [width_p-1:0]               data_i,
    output logic                             ready_o,
    output logic                             valid_o,
    output logic [kernel_rows_p*width_p-1:0] data_o,
    input  logic                             ready_i
`ifdef CONV2D_LINE_BUFFER_EOL_EN
    ,
    output logic                             eol_o
`endif
);

    localparam int col_w_lp  = $clog2(line_width_p);
    localparam int row_w_lp  = $clog2(kernel_rows_p);
    localparam int n_rams_lp = kernel_rows_p - 1;

    localparam logic [col_w_lp-1:0] col_last_lp = col_w_lp'(line_width_p - 1);
    localparam logic [row_w_lp-1:0] row_full_lp = row_w_lp'(kernel_rows_p - 1);

    // Control state
    logic [col_w_lp-1:0] col_q, col_d;
    logic [row_w_lp-1:0] row_q, row_d;
    logic                s1_full_q, s1_full_d;
    logic                s1_rowok_q, s1_rowok_d;
    logic                s1_new_q, s1_new_d;
    logic [col_w_lp-1:0] s1_col_q, s1_col_d;

    // Stage-1 pixel; qualified by s1_full_q, so it needs no reset
    logic [width_p-1:0]  s1_pix_q;

    logic                acc;
    logic                xfer;
    logic                col_wrap;
    logic                ram_we;
    logic [width_p-1:0]  rd_data [n_rams_lp];

    assign ready_o  = ~s1_full_q | ready_i;
    assign acc      = valid_i & ready_o;
    assign valid_o  = s1_full_q & s1_rowok_q;
    assign xfer     = valid_o & ready_i;
    assign col_wrap = (col_q == col_last_lp);

    // A write is pending the cycle after an accept. Reset suppresses it so a
    // reset in mid-flight leaves no partial column shift behind.
    assign ram_we   = s1_new_q & ~reset_i;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        s1_full_d  = s1_full_q;
        s1_rowok_d = s1_rowok_q;
        s1_col_d   = s1_col_q;
        s1_new_d   = acc;

        if (acc) begin
            col_d      = col_wrap ? '0 : col_q + 1'b1;
            s1_col_d   = col_q;
            s1_rowok_d = (row_q == row_full_lp);
            if (col_wrap && (row_q != row_full_lp)) begin
                row_d = row_q + 1'b1;
            end
        end

        // An entry that will never be emitted (priming rows) drains by itself.
        // A new accept in the same cycle keeps the stage full.
        if (acc) begin
            s1_full_d = 1'b1;
        end else if (s1_full_q && (xfer || !s1_rowok_q)) begin
            s1_full_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. That way
    // every flop samples pre-edge values, whatever order the blocks run in.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            col_q      <= '0;
            row_q      <= '0;
            s1_full_q  <= 1'b0;
            s1_rowok_q <= 1'b0;
            s1_new_q   <= 1'b0;
            s1_col_q   <= '0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            s1_full_q  <= s1_full_d;
            s1_rowok_q <= s1_rowok_d;
            s1_new_q   <= s1_new_d;
            s1_col_q   <= s1_col_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (acc) begin
            s1_pix_q <= data_i;
        end
    end

    // Vertical shift chain: RAM 0 takes the newest pixel. RAM k takes what
    // RAM k-1 read for the same column one cycle earlier.
    for (genvar k = 0; k < n_rams_lp; k++) begin : g_ram
        logic [width_p-1:0] wr_data;

        if (k == 0) begin : g_head
            assign wr_data = s1_pix_q;
        end else begin : g_chain
            assign wr_data = rd_data[k-1];
        end

        ram_1r1w_sync #(
            .width_p (width_p),
            .els_p   (line_width_p)
        ) u_ram (
            .clk_i      (clk_i),
            .wr_v_i     (ram_we),
            .wr_addr_i  (s1_col_q),
            .wr_data_i  (wr_data),
            .rd_valid_i (acc),
            .rd_addr_i  (col_q),
            .rd_data_o  (rd_data[k])
        );
    end

    always_comb begin
        data_o              = '0;
        data_o[width_p-1:0] = s1_pix_q;
        for (int k = 0; k < n_rams_lp; k++) begin
            data_o[(k+1)*width_p +: width_p] = rd_data[k];
        end
    end

`ifdef CONV2D_LINE_BUFFER_EOL_EN
    assign eol_o = (s1_col_q == col_last_lp);
`endif

endmodule

// File: tb/tb_conv2d_line_buffer.sv
// -----------------------------------------------------------------------------
// tb_conv2d_line_buffer
//
// Directed test of conv2d_line_buffer with width_p=8, line_width_p=4 and
// kernel_rows_p=3. A pixel at (row r, col c) has value 16*r+c, so the
// expected column for row r is {16*(r-2)+c, 16*(r-1)+c, 16*r+c}. The stimulus
// pushes the expected columns into a queue. A monitor pops them and compares
// on every output transfer.
// Define CONV2D_LINE_BUFFER_EOL_EN to also check eol_o.
// -----------------------------------------------------------------------------

module tb_conv2d_line_buffer;

    localparam int W  = 8;
    localparam int LW = 4;
    localparam int K  = 3;

    typedef struct packed {
        logic [K*W-1:0] data;
        logic           eol;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset_i;
    logic           valid_i;
    logic [W-1:0]   data_i;
    logic           ready_o;
    logic           valid_o;
    logic [K*W-1:0] data_o;
    logic           ready_i;
`ifdef CONV2D_LINE_BUFFER_EOL_EN
    logic           eol_o;
`endif

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    bit   rand_ready = 1'b0;
    logic ready_hold = 1'b1;

    always #5 clk = ~clk;

    conv2d_line_buffer #(
        .width_p       (W),
        .line_width_p  (LW),
        .kernel_rows_p (K)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .valid_i (valid_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .ready_i (ready_i)
`ifdef CONV2D_LINE_BUFFER_EOL_EN
        ,
        .eol_o   (eol_o)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic logic [K*W-1:0] exp_col(input int r, input int c);
        logic [W-1:0] oldest, middle, newest;
        oldest = W'(16 * (r - 2) + c);
        middle = W'(16 * (r - 1) + c);
        newest = W'(16 * r + c);
        return {oldest, middle, newest};
    endfunction

    function automatic logic next_ready();
        return rand_ready ? 1'($urandom_range(0, 1)) : ready_hold;
    endfunction

    // Offers pixel (r,c) until it is accepted. If push is set, the column
    // the pixel should produce is queued for the monitor.
    task automatic send(input int r, input int c, input bit push);
        bit done;
        int guard;
        exp_t e;
        done  = 1'b0;
        guard = 0;
        while (!done) begin
            @(negedge clk);
            valid_i = 1'b1;
            data_i  = W'(16 * r + c);
            ready_i = next_ready();
            #1;
            if (ready_o) begin
                if (push) begin
                    e.data = exp_col(r, c);
                    e.eol  = (c == LW - 1);
                    exp_q.push_back(e);
                end
                @(posedge clk);
                done = 1'b1;
            end else begin
                guard++;
                if (guard > 50) begin
                    check("accept_timeout", 32'(ready_o), 32'd1);
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic send_row(input int r, input bit push);
        for (int c = 0; c < LW; c++) begin
            send(r, c, push);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            valid_i = 1'b0;
            ready_i = next_ready();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_i = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        ready_i = 1'b1;
        #1;
        check("reset_valid_o", 32'(valid_o), 32'd0);
        check("reset_ready_o", 32'(ready_o), 32'd1);
    endtask

    task automatic drain();
        int guard;
        rand_ready = 1'b0;
        ready_hold = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            idle(1);
            guard++;
        end
        idle(2);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: samples away from the rising edge. Any transfer it sees will
    // complete on the next rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset_i && valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=0x%0h required=no output", data_o);
                end else begin
                    e = exp_q.pop_front();
                    check("column_data", 32'(data_o), 32'(e.data));
`ifdef CONV2D_LINE_BUFFER_EOL_EN
                    check("column_eol", 32'(eol_o), 32'(e.eol));
`endif
                end
            end
        end
    end

    initial begin
        reset_i = 1'b1;
        valid_i = 1'b0;
        data_i  = '0;
        ready_i = 1'b1;
        repeat (3) @(posedge clk);
        do_reset();

        // Prime rows 0-1: ready_o must stay high and nothing may be emitted.
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < LW; c++) begin
                send(r, c, 1'b0);
                check("prime_ready_o", 32'(ready_o), 32'd1);
            end
        end
        idle(1);
        #1;
        check("prime_valid_o", 32'(valid_o), 32'd0);

        // Row 2: first full windows (0x001020 ... 0x031323, eol on col 3).
        send_row(2, 1'b1);

        // Row 3 with a 5-cycle downstream stall after col 1. Col 2 is
        // offered during the stall and must not be taken.
        send(3, 0, 1'b1);
        send(3, 1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            valid_i = 1'b1;
            data_i  = 8'h32;
            ready_i = 1'b0;
            #1;
            check("stall_valid_o", 32'(valid_o), 32'd1);
            check("stall_data_o", 32'(data_o), 32'h112131);
            check("stall_ready_o", 32'(ready_o), 32'd0);
        end
        ready_hold = 1'b1;
        send(3, 2, 1'b1);
        send(3, 3, 1'b1);

        // Six rows back to back with random downstream backpressure.
        rand_ready = 1'b1;
        for (int r = 4; r < 10; r++) begin
            send_row(r, 1'b1);
        end
        drain();

        // Reset, re-prime, then reset mid-row 3 with col 1 still in flight.
        do_reset();
        send_row(0, 1'b0);
        send_row(1, 1'b0);
        send_row(2, 1'b1);
        send(3, 0, 1'b1);
        send(3, 1, 1'b0);
        do_reset();

        // Two fresh rows (values 0xC?, 0xD?) must not be emitted.
        send_row(12, 1'b0);
        send_row(13, 1'b0);
        idle(1);
        #1;
        check("reprime_valid_o", 32'(valid_o), 32'd0);
        // The third fresh row gives {0xCc, 0xDc, 0xEc}.
        send_row(14, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so that the run always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "time limit reached");
    end

endmodule
